pot_sweep_reader: RTL
=====================

Name: pot_sweep_reader

Overview:
- Produces the 12-bit slider/pot codes consumed by the per-band gain scalers and the volume stage.
- Round-robins six channels of an external 8-channel 12-bit SPI A2D (ADC128S-style).
- Two 16-bit SPI frames per channel: the first frame selects the channel, the second frame returns its conversion.
- Results are held in six output registers.

Parameters:
- SCLK_DIV, 32: clk cycles per SCLK period. Must be even and ≥ 4.
- GAP, 32: clk cycles with SS_n high between consecutive frames. Must be ≥ 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  sweep enable, level-sensitive
- MISO  in  1  A2D serial data out
- SS_n  out  1  A2D chip select, active low
- SCLK  out  1  A2D serial clock, idles high
- MOSI  out  1  A2D serial data in
- POT_LP  out  12  low-pass band pot (A2D channel 1)
- POT_B1  out  12  band 1 pot (channel 0)
- POT_B2  out  12  band 2 pot (channel 4)
- POT_B3  out  12  band 3 pot (channel 2)
- POT_HP  out  12  high-pass band pot (channel 3)
- VOLUME  out  12  volume pot (channel 7)
- sweep_done  out  1  one-cycle pulse after VOLUME is updated

Behaviour:
- Reset, asynchronous and effective immediately, including mid-frame:
  - SS_n=1, SCLK=1, MOSI=0, sweep_done=0.
  - All POT outputs = 12'h000.
  - Sequencer goes to IDLE with slot index 0.
  - No partial result is ever written.
- States:
  - IDLE: if en is high, go to CMD on the next clk.
  - CMD: frame 1. Sends command word {2'b00, ch[2:0], 11'h000}; the bits received on MISO are discarded.
  - GAP1: GAP cycles with SS_n high.
  - READ: frame 2. Sends the same command word.
  - UPD: one cycle. Writes the result to the slot's register, then advances the slot.
  - GAP2: GAP cycles with SS_n high. Then go to CMD if en is high, else IDLE.
- Slot order: LP(ch1) → B1(ch0) → B2(ch4) → B3(ch2) → HP(ch3) → VOLUME(ch7), then wrap to LP.
- Frame timing, with H = SCLK_DIV/2:
  - SS_n falls on entry to the frame state.
  - MOSI presents bit 15 in that same cycle.
  - SCLK goes low H cycles after SS_n falls, then toggles every H cycles, giving 16 low/high periods.
  - MOSI updates to the next bit on each SCLK falling edge after the first.
  - MISO is sampled into a 16-bit shift register, MSB first, on the clk that drives each SCLK rising edge.
  - After the 16th rising edge, SCLK stays high; SS_n rises H cycles later.
  - SS_n is low for exactly 16·SCLK_DIV + H clk cycles (528 at default).
  - MOSI returns to 0 while SS_n is high.
- Result and registers:
  - Result = shift register bits [11:0]; bits [15:12] are ignored.
  - Only the addressed register changes in UPD; the other five hold their values.
- sweep_done: pulses high in the cycle after the UPD that writes VOLUME.
- en handling:
  - en is sampled only in IDLE and at the end of GAP2.
  - Deasserting en mid-channel completes that channel's CMD/READ pair and its update, then the block idles.
  - The slot index is retained in IDLE, so the sweep resumes at the next slot rather than restarting at LP.
- No back-pressure: outputs are plain registers that consumers may read at any time, and each changes only in its UPD cycle.

Test Plan:
- Reset mid-READ of slot B2 (rst pulse at cycle 300 of the frame) → SS_n, SCLK high and all POTs 0 within the same cycle, before the next clk edge. After release with en=1, the first frame addresses ch1.
- en=1, A2D model returns 12'hA5C for every channel → frame 1 MOSI word 16'h0800 (ch1). SS_n low exactly 528 cycles per frame. POT_LP=12'hA5C after the first READ; other POTs stay 0 until their slots.
- A2D model returns 12'h100+ch for channel ch → after one sweep: POT_LP=101, B1=100, B2=104, B3=102, HP=103, VOLUME=107 (hex). sweep_done pulses exactly once. MOSI channel order is 1,0,4,2,3,7.
- MISO drives 4'hF in bits [15:12] with 12'hFFF data → register = 12'hFFF, with no corruption from the upper bits. Data 12'h000 → register = 0.
- en dropped during the CMD frame of B3 → B3 READ and update still complete, then the block is IDLE (SS_n held high). Re-asserting en → next frame addresses ch3 (HP).
- SCLK_DIV=4, GAP=1 override → SS_n low for 66 cycles per frame. Results match the default-parameter run.

Source files
------------

// File: rtl/pot_sweep_reader.sv
// Purpose : round-robin reader for six pots on an 8-channel 12-bit SPI A2D; each channel takes a command frame then a read frame.
// Latency : a result reaches its POT register one cycle after its read frame ends; a full sweep takes about 6*(2*(16*SCLK_DIV+SCLK_DIV/2)+2*GAP+1) clk cycles.
// Backpr. : none; the POT outputs are plain registers that consumers may read at any time, and each changes only in its own update cycle.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   en              sweep enable; sampled in IDLE and at the end of the post-update gap
//   MISO            serial data from the A2D
//   SS_n/SCLK/MOSI  SPI master outputs (SCLK idles high)
//   POT_*/VOLUME    12-bit results, one register per slot
//   sweep_done      one-cycle pulse when VOLUME has just been written
module pot_sweep_reader #(
  parameter int SCLK_DIV = 32,
  parameter int GAP      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] POT_LP,
  output logic [11:0] POT_B1,
  output logic [11:0] POT_B2,
  output logic [11:0] POT_B3,
  output logic [11:0] POT_HP,
  output logic [11:0] VOLUME,
  output logic        sweep_done
);

  localparam int H       = SCLK_DIV / 2;
  localparam int CNT_MAX = (H > GAP) ? H : GAP;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    GAP1 = 3'd2,
    READ = 3'd3,
    UPD  = 3'd4,
    GAP2 = 3'd5
  } state_t;

  state_t      state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  // Half-period index inside a frame: 0 is the initial high half after SS_n
  // falls; odd values are SCLK-low halves, even values >= 2 are SCLK-high
  // halves. Index 32 is the final high half, after which SS_n rises.
  logic [5:0]  hidx, nxt_hidx;
  logic [2:0]  slot;
  // Only the low 12 bits of the 16-bit frame are ever used, and after 16
  // shifts those are exactly the last 12 bits received.
  logic [11:0] shreg;

  logic        nxt_in_frame;
  logic        nxt_sclk;
  logic        nxt_mosi;
  logic        sample;
  logic [3:0]  nxt_bit;
  logic [15:0] cmd_word;
  logic [2:0]  slot_ch;

  // Slot order LP, B1, B2, B3, HP, VOLUME -> A2D channels 1, 0, 4, 2, 3, 7.
  always_comb begin
    slot_ch = 3'd1;
    case (slot)
      3'd0:    slot_ch = 3'd1;
      3'd1:    slot_ch = 3'd0;
      3'd2:    slot_ch = 3'd4;
      3'd3:    slot_ch = 3'd2;
      3'd4:    slot_ch = 3'd3;
      3'd5:    slot_ch = 3'd7;
      default: slot_ch = 3'd1;
    endcase
  end

  assign cmd_word = {2'b00, slot_ch, 11'h000};

  // Next-state logic. Every entry into a frame or gap restarts the counters.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_hidx  = hidx;
    case (state)
      IDLE: begin
        if (en) begin
          nxt_state = CMD;
          nxt_cnt   = '0;
          nxt_hidx  = '0;
        end
      end
      CMD, READ: begin
        if (cnt == CW'(H - 1)) begin
          nxt_cnt = '0;
          if (hidx == 6'd32) begin
            nxt_hidx  = '0;
            nxt_state = (state == CMD) ? GAP1 : UPD;
          end else begin
            nxt_hidx = hidx + 6'd1;
          end
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end
      GAP1: begin
        if (cnt == CW'(GAP - 1)) begin
          nxt_state = READ;
          nxt_cnt   = '0;
          nxt_hidx  = '0;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end
      UPD: begin
        nxt_state = GAP2;
        nxt_cnt   = '0;
      end
      GAP2: begin
        if (cnt == CW'(GAP - 1)) begin
          nxt_state = en ? CMD : IDLE;
          nxt_cnt   = '0;
          nxt_hidx  = '0;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
        nxt_hidx  = '0;
      end
    endcase
  end

  // SPI pins are registered from the next-state view so they change on the
  // same clk edge as the sequencer and never glitch.
  always_comb begin
    nxt_in_frame = (nxt_state == CMD) || (nxt_state == READ);
    nxt_sclk     = !(nxt_in_frame && nxt_hidx[0]);
    // Bit 15 is held through the first low half; each later falling edge
    // (odd hidx >= 3) moves on by one bit.
    nxt_bit      = (nxt_hidx == 6'd0) ? 4'd0 : 4'((nxt_hidx - 6'd1) >> 1);
    nxt_mosi     = nxt_in_frame ? cmd_word[4'd15 - nxt_bit] : 1'b0;
    // Sample on the edge that raises SCLK (start of an even half >= 2).
    sample       = nxt_in_frame && (nxt_cnt == '0) && !nxt_hidx[0] && (nxt_hidx != 6'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hidx       <= '0;
      slot       <= 3'd0;
      shreg      <= '0;
      SS_n       <= 1'b1;
      SCLK       <= 1'b1;
      MOSI       <= 1'b0;
      sweep_done <= 1'b0;
      POT_LP     <= 12'h000;
      POT_B1     <= 12'h000;
      POT_B2     <= 12'h000;
      POT_B3     <= 12'h000;
      POT_HP     <= 12'h000;
      VOLUME     <= 12'h000;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      hidx       <= nxt_hidx;
      SS_n       <= !nxt_in_frame;
      SCLK       <= nxt_sclk;
      MOSI       <= nxt_mosi;
      sweep_done <= (state == UPD) && (slot == 3'd5);
      if (sample) begin
        shreg <= {shreg[10:0], MISO};
      end
      if (state == UPD) begin
        case (slot)
          3'd0:    POT_LP <= shreg;
          3'd1:    POT_B1 <= shreg;
          3'd2:    POT_B2 <= shreg;
          3'd3:    POT_B3 <= shreg;
          3'd4:    POT_HP <= shreg;
          3'd5:    VOLUME <= shreg;
          default: POT_LP <= POT_LP;
        endcase
        slot <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
      end
    end
  end

endmodule
